// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART Tx engine between two byte requesters.
// Sequences LOAD/TXRDY one byte at a time and supplies the bit-time divisor K.
module uart_tx_scheduler #(
  parameter logic [18:0] K_SEL0   = 19'd10416,
  parameter logic [18:0] K_SEL1   = 19'd5207,
  parameter logic [18:0] K_SEL2   = 19'd1735,
  parameter logic [18:0] K_SEL3   = 19'd867,
  parameter int          WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [7:0]  data0,
  input  logic [7:0]  data1,
  output logic [1:0]  ack,
  output logic        tx_load,
  output logic [7:0]  tx_data,
  input  logic        tx_rdy,
  input  logic [1:0]  baud_sel,
  output logic [18:0] k_out,
  output logic        busy,
  output logic        err,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD      = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;
  localparam int CW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

  // Handshake: a requester holds req[i] (and its data) until it sees ack[i]
  // for one cycle; ack always coincides with the tx_load pulse to the engine.
  logic [1:0]    state;
  logic          rr_ptr;
  logic          winner;
  logic          pick;
  logic [CW-1:0] wait_cnt;
  logic [18:0]   k_sel;

  // Both requesting: rr_ptr decides; otherwise the lone requester wins.
  assign pick = (req == 2'b11) ? rr_ptr : req[1];

  always_comb begin
    k_sel = K_SEL0;
    case (baud_sel)
      2'd0:    k_sel = K_SEL0;
      2'd1:    k_sel = K_SEL1;
      2'd2:    k_sel = K_SEL2;
      default: k_sel = K_SEL3;
    endcase
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ack      <= 2'b00;
      tx_load  <= 1'b0;
      tx_data  <= 8'h00;
      err      <= 1'b0;
      rr_ptr   <= 1'b0;
      winner   <= 1'b0;
      k_out    <= K_SEL0;
      wait_cnt <= '0;
    end else begin
      ack     <= 2'b00;
      tx_load <= 1'b0;
      case (state)
        IDLE: begin
          k_out <= k_sel;
          if (tx_rdy && (req != 2'b00)) begin
            winner  <= pick;
            tx_data <= pick ? data1 : data0;
            ack     <= pick ? 2'b10 : 2'b01;
            tx_load <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          wait_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!tx_rdy) begin
            state <= WAIT_DONE;
          end else if (wait_cnt == CW'(WAIT_MAX - 1)) begin
            // Engine never went busy: flag it but keep the arbitration order.
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (tx_rdy) begin
            rr_ptr <= ~winner;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: vector table for single-cycle steps plus
// hand sequences for contention, timeout and asynchronous reset.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [7:0]  data0 = 8'h00;
  logic [7:0]  data1 = 8'h00;
  logic [1:0]  ack;
  logic        tx_load;
  logic [7:0]  tx_data;
  logic        tx_rdy = 1'b1;
  logic [1:0]  baud_sel = 2'd0;
  logic [18:0] k_out;
  logic        busy;
  logic        err;
  logic [1:0]  fsm_state;

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  uart_tx_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data0(data0), .data1(data1),
    .ack(ack), .tx_load(tx_load), .tx_data(tx_data), .tx_rdy(tx_rdy),
    .baud_sel(baud_sel), .k_out(k_out), .busy(busy), .err(err),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        rdy;
    logic [1:0]  baud;
    logic [1:0]  e_ack;
    logic        e_load;
    logic [7:0]  e_data;
    logic        e_busy;
    logic [18:0] e_k;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [7:0] d0, input logic [7:0] d1,
                       input logic rdy, input logic [1:0] b);
    req = r; data0 = d0; data1 = d1; tx_rdy = rdy; baud_sel = b;
  endtask

  task automatic wait_load(input string name);
    int n;
    n = 0;
    while (!tx_load && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!tx_load) check({name, "_load_timeout"}, 32'(tx_load), 32'd1);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_ack"},   32'(ack),       32'd0);
    check({name, "_load"},  32'(tx_load),   32'd0);
    check({name, "_data"},  32'(tx_data),   32'd0);
    check({name, "_busy"},  32'(busy),      32'd0);
    check({name, "_err"},   32'(err),       32'd0);
    check({name, "_k"},     32'(k_out),     32'd10416);
    check({name, "_state"}, 32'(fsm_state), 32'd0);
  endtask

  initial begin
    logic [9:0] exp;
    // state: 0 IDLE, 1 LOAD, 2 WAIT_BUSY, 3 WAIT_DONE
    vecs[0]  = '{2'b01, 8'hA5, 8'h00, 1'b1, 2'd0, 2'b01, 1'b1, 8'hA5, 1'b1, 19'd10416, 2'd1};
    vecs[1]  = '{2'b00, 8'h00, 8'h00, 1'b1, 2'd0, 2'b00, 1'b0, 8'hA5, 1'b1, 19'd10416, 2'd2};
    vecs[2]  = '{2'b00, 8'h00, 8'h00, 1'b0, 2'd0, 2'b00, 1'b0, 8'hA5, 1'b1, 19'd10416, 2'd3};
    vecs[3]  = '{2'b00, 8'h00, 8'h00, 1'b0, 2'd0, 2'b00, 1'b0, 8'hA5, 1'b1, 19'd10416, 2'd3};
    vecs[4]  = '{2'b00, 8'h00, 8'h00, 1'b1, 2'd0, 2'b00, 1'b0, 8'hA5, 1'b0, 19'd10416, 2'd0};
    vecs[5]  = '{2'b10, 8'h00, 8'h3C, 1'b0, 2'd0, 2'b00, 1'b0, 8'hA5, 1'b0, 19'd10416, 2'd0};
    vecs[6]  = '{2'b10, 8'h00, 8'h3C, 1'b0, 2'd0, 2'b00, 1'b0, 8'hA5, 1'b0, 19'd10416, 2'd0};
    vecs[7]  = '{2'b10, 8'h00, 8'h3C, 1'b1, 2'd0, 2'b10, 1'b1, 8'h3C, 1'b1, 19'd10416, 2'd1};
    vecs[8]  = '{2'b00, 8'h00, 8'hFF, 1'b1, 2'd3, 2'b00, 1'b0, 8'h3C, 1'b1, 19'd10416, 2'd2};
    vecs[9]  = '{2'b00, 8'h00, 8'hFF, 1'b0, 2'd3, 2'b00, 1'b0, 8'h3C, 1'b1, 19'd10416, 2'd3};
    vecs[10] = '{2'b00, 8'h00, 8'hFF, 1'b1, 2'd3, 2'b00, 1'b0, 8'h3C, 1'b0, 19'd10416, 2'd0};
    vecs[11] = '{2'b00, 8'h00, 8'h00, 1'b1, 2'd3, 2'b00, 1'b0, 8'h3C, 1'b0, 19'd867,   2'd0};
    vecs[12] = '{2'b00, 8'h00, 8'h00, 1'b1, 2'd1, 2'b00, 1'b0, 8'h3C, 1'b0, 19'd5207,  2'd0};
    vecs[13] = '{2'b00, 8'h00, 8'h00, 1'b1, 2'd2, 2'b00, 1'b0, 8'h3C, 1'b0, 19'd1735,  2'd0};
    vecs[14] = '{2'b00, 8'h00, 8'h00, 1'b1, 2'd0, 2'b00, 1'b0, 8'h3C, 1'b0, 19'd10416, 2'd0};

    // reset
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;
    @(negedge clk);

    // single transfer, blocked engine, baud change mid-frame
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].req, vecs[i].d0, vecs[i].d1, vecs[i].rdy, vecs[i].baud);
      @(negedge clk);
      check($sformatf("v%0d_ack", i),   32'(ack),       32'(vecs[i].e_ack));
      check($sformatf("v%0d_load", i),  32'(tx_load),   32'(vecs[i].e_load));
      check($sformatf("v%0d_data", i),  32'(tx_data),   32'(vecs[i].e_data));
      check($sformatf("v%0d_busy", i),  32'(busy),      32'(vecs[i].e_busy));
      check($sformatf("v%0d_k", i),     32'(k_out),     32'(vecs[i].e_k));
      check($sformatf("v%0d_state", i), 32'(fsm_state), 32'(vecs[i].e_state));
      check($sformatf("v%0d_err", i),   32'(err),       32'd0);
    end

    // contention: both held, bytes and acks must alternate starting with req0
    exp_q.push_back({2'b01, 8'h11});
    exp_q.push_back({2'b10, 8'h22});
    exp_q.push_back({2'b01, 8'h11});
    exp_q.push_back({2'b10, 8'h22});
    drive(2'b11, 8'h11, 8'h22, 1'b1, 2'd0);
    for (int f = 0; f < 4; f++) begin
      wait_load($sformatf("rr%0d", f));
      exp = exp_q.pop_front();
      check($sformatf("rr%0d_ack", f),  32'(ack),     32'(exp[9:8]));
      check($sformatf("rr%0d_data", f), 32'(tx_data), 32'(exp[7:0]));
      if (f == 3) req = 2'b00;
      tx_rdy = 1'b0;
      repeat (3) @(negedge clk);
      tx_rdy = 1'b1;
      @(negedge clk);
    end
    check("rr_idle", 32'(busy), 32'd0);

    // timeout: engine stays ready after LOAD
    drive(2'b01, 8'h55, 8'h00, 1'b1, 2'd0);
    wait_load("to");
    check("to_ack", 32'(ack), 32'd1);
    req = 2'b00;
    repeat (8) @(negedge clk);
    check("to_err_early", 32'(err), 32'd0);
    check("to_busy_early", 32'(busy), 32'd1);
    @(negedge clk);
    check("to_err", 32'(err), 32'd1);
    check("to_busy", 32'(busy), 32'd0);

    // after timeout requester 0 still has priority, and err stays set while serving
    drive(2'b11, 8'h77, 8'h88, 1'b1, 2'd0);
    wait_load("post_to");
    check("post_to_ack", 32'(ack), 32'd1);
    check("post_to_data", 32'(tx_data), 32'h77);
    req = 2'b00;
    tx_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_state", 32'(fsm_state), 32'd3);
    check("pre_rst_err", 32'(err), 32'd1);

    // asynchronous reset in WAIT_DONE, sampled before any clock edge
    #2 rst_n = 1'b0;
    #1 check_reset_values("arst");
    @(negedge clk);
    rst_n = 1'b1;
    tx_rdy = 1'b1;
    @(negedge clk);
    check("arst_idle_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
